// File: rtl/ddr_refresh_scheduler_pkg.sv
// Shared types and default timing for the DDR4 auto-refresh scheduler.
// Timing defaults are CK_t cycles at 1.25 ns.
package ddr_refresh_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        PREA     = 3'd2,
        WAIT_RP  = 3'd3,
        REF      = 3'd4,
        WAIT_RFC = 3'd5
    } ref_state_e;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PREA = 2'd1,
        CMD_REF  = 2'd2
    } ref_cmd_e;

    localparam int unsigned DEF_T_REFI       = 6240;
    localparam int unsigned DEF_T_RFC        = 280;
    localparam int unsigned DEF_T_RP         = 14;
    localparam int unsigned DEF_MAX_POSTPONE = 8;
    localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/ddr_refresh_scheduler_if.sv
// Command-path handshake between the refresh scheduler (master) and the
// arbiter / command bus side (slave).
interface ddr_refresh_scheduler_if;
    import ddr_refresh_scheduler_pkg::*;

    logic     ctrl_idle;
    logic     banks_open;
    logic     block_cmd;
    logic     cmd_valid;
    ref_cmd_e cmd_type;
    logic     cmd_ack;

    modport master (
        input  ctrl_idle,
        input  banks_open,
        input  cmd_ack,
        output block_cmd,
        output cmd_valid,
        output cmd_type
    );

    modport slave (
        output ctrl_idle,
        output banks_open,
        output cmd_ack,
        input  block_cmd,
        input  cmd_valid,
        input  cmd_type
    );

endinterface

// File: rtl/ddr_refresh_scheduler_refi_timer.sv
// tREFI interval counter: one-cycle tick on the last cycle of each interval,
// held at zero while disabled.
module refi_timer
    import ddr_refresh_scheduler_pkg::*;
#(
    parameter int unsigned T_REFI = DEF_T_REFI,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic CK_t,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(T_REFI - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick = en && (cnt_q == LAST);
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr_refresh_scheduler.sv
// DDR4 auto-refresh scheduler: tracks owed refreshes with postponement and
// sequences PREA/REF on the command path when the arbiter is idle or refresh is urgent.
module ddr_refresh_scheduler
    import ddr_refresh_scheduler_pkg::*;
#(
    parameter int unsigned T_REFI       = DEF_T_REFI,
    parameter int unsigned T_RFC        = DEF_T_RFC,
    parameter int unsigned T_RP         = DEF_T_RP,
    parameter int unsigned MAX_POSTPONE = DEF_MAX_POSTPONE,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                           CK_t,
    input  logic                           reset,
    input  logic                           init_done,
    ddr_refresh_scheduler_if.master        bus,
    output logic [3:0]                     refresh_owed,
    output logic                           urgent,
    output logic                           refresh_err
);

    localparam logic [3:0]       MAX_OWED = 4'(MAX_POSTPONE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Wait counters are loaded on the ack cycle, so the ack itself is the first timed cycle.
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);

    logic             refi_tick;
    logic             rfc_last;

    ref_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       owed_q, owed_d;
    logic             err_q, err_d;
    logic             urgent_q, urgent_d;
    logic             block_q, block_d;
    logic             valid_q, valid_d;
    ref_cmd_e         type_q, type_d;

    refi_timer #(
        .T_REFI (T_REFI),
        .CNT_W  (CNT_W)
    ) u_refi_timer (
        .CK_t  (CK_t),
        .reset (reset),
        .en    (init_done),
        .tick  (refi_tick)
    );

    // Owed-refresh bookkeeping; a tick and a completion in the same cycle cancel.
    always_comb begin
        rfc_last = (state_q == WAIT_RFC) && (cnt_q <= CNT_ONE);
        owed_d   = owed_q;
        err_d    = err_q;
        if (refi_tick && !rfc_last) begin
            if (owed_q == MAX_OWED) begin
                err_d = 1'b1;
            end else begin
                owed_d = owed_q + 4'd1;
            end
        end else if (rfc_last && !refi_tick && (owed_q != '0)) begin
            owed_d = owed_q - 4'd1;
        end
        urgent_d = (owed_d == MAX_OWED);
    end

    // Next-state uses owed_d so a fresh tick is acted on without an extra cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (init_done && (owed_d != '0) && (bus.ctrl_idle || urgent_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.ctrl_idle) begin
                    state_d = bus.banks_open ? PREA : REF;
                end
            end
            PREA: begin
                if (bus.cmd_ack) begin
                    state_d = WAIT_RP;
                    cnt_d   = RP_LOAD;
                end
            end
            WAIT_RP: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = REF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REF: begin
                if (bus.cmd_ack) begin
                    state_d = WAIT_RFC;
                    cnt_d   = RFC_LOAD;
                end
            end
            WAIT_RFC: begin
                if (rfc_last) begin
                    cnt_d   = '0;
                    state_d = (init_done && (owed_d != '0) && bus.ctrl_idle) ? REF : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        block_d = (state_d != IDLE);
        valid_d = (state_d == PREA) || (state_d == REF);
        if (state_d == PREA) begin
            type_d = CMD_PREA;
        end else if (state_d == REF) begin
            type_d = CMD_REF;
        end else begin
            type_d = CMD_NOP;
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owed_q   <= '0;
            err_q    <= 1'b0;
            urgent_q <= 1'b0;
            block_q  <= 1'b0;
            valid_q  <= 1'b0;
            type_q   <= CMD_NOP;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owed_q   <= owed_d;
            err_q    <= err_d;
            urgent_q <= urgent_d;
            block_q  <= block_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
        end
    end

    assign bus.block_cmd = block_q;
    assign bus.cmd_valid = valid_q;
    assign bus.cmd_type  = type_q;
    assign refresh_owed  = owed_q;
    assign urgent        = urgent_q;
    assign refresh_err   = err_q;

endmodule

// File: tb/tb_ddr_refresh_scheduler.sv
// Self-checking bench for ddr_refresh_scheduler with shortened timing.
// A per-cycle owed/err model and tRP/tRFC spacing rules run alongside directed tables and random traffic.
module tb_ddr_refresh_scheduler;
    import ddr_refresh_scheduler_pkg::*;

    localparam int T_REFI = 100;
    localparam int T_RFC  = 20;
    localparam int T_RP   = 5;
    localparam int MAXP   = 8;

    logic       CK_t = 1'b0;
    logic       reset;
    logic       init_done;
    logic [3:0] refresh_owed;
    logic       urgent;
    logic       refresh_err;

    ddr_refresh_scheduler_if bus();

    ddr_refresh_scheduler #(
        .T_REFI       (T_REFI),
        .T_RFC        (T_RFC),
        .T_RP         (T_RP),
        .MAX_POSTPONE (MAXP),
        .CNT_W        (16)
    ) dut (
        .CK_t         (CK_t),
        .reset        (reset),
        .init_done    (init_done),
        .bus          (bus),
        .refresh_owed (refresh_owed),
        .urgent       (urgent),
        .refresh_err  (refresh_err)
    );

    always #5 CK_t = ~CK_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state
    int m_owed = 0;
    bit m_err  = 1'b0;
    int m_elapsed = 0;
    int done_q[$];
    int last_prea_ack = -1000;
    int last_ref_ack  = -1000;

    bit auto_ack = 1'b0;
    int ack_pct  = 100;
    bit rand_in  = 1'b0;
    int idle_pct = 60;

    typedef struct {
        int       n;
        logic     idle;
        logic     bo;
        logic     ack;
        logic     blk;
        logic     vld;
        ref_cmd_e typ;
        int       owed;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int n, input logic idle, input logic bo, input logic ack,
                       input logic blk, input logic vld, input ref_cmd_e typ, input int owed);
        tbl.push_back('{n, idle, bo, ack, blk, vld, typ, owed});
    endtask

    // Compare DUT to model at the falling edge, then advance the model across the next rising edge.
    task automatic sample();
        bit tick_n;
        bit done_n;
        @(negedge CK_t);
        if (reset) begin
            m_owed = 0;
            m_err = 1'b0;
            m_elapsed = 0;
            done_q.delete();
            last_prea_ack = -1000;
            last_ref_ack = -1000;
            cyc++;
            return;
        end
        check("owed", int'(refresh_owed), m_owed);
        check("urgent", int'(urgent), int'(m_owed == MAXP));
        check("err", int'(refresh_err), int'(m_err));
        if (!bus.cmd_valid) begin
            check("nop_when_invalid", int'(bus.cmd_type), int'(CMD_NOP));
        end else begin
            check("block_with_valid", int'(bus.block_cmd), 1);
            if (bus.cmd_type == CMD_REF) begin
                check("ref_after_trp", int'(cyc >= last_prea_ack + T_RP), 1);
            end else begin
                check("valid_type_prea", int'(bus.cmd_type), int'(CMD_PREA));
            end
            check("cmd_after_trfc", int'(cyc >= last_ref_ack + T_RFC), 1);
        end

        tick_n = init_done && (m_elapsed == T_REFI - 1);
        done_n = (done_q.size() > 0) && (done_q[0] == cyc);
        if (done_n) void'(done_q.pop_front());
        if (bus.cmd_valid && bus.cmd_ack) begin
            if (bus.cmd_type == CMD_REF) begin
                last_ref_ack = cyc;
                done_q.push_back(cyc + T_RFC - 1);
            end else begin
                last_prea_ack = cyc;
            end
        end
        m_elapsed = (!init_done || tick_n) ? 0 : m_elapsed + 1;
        if (tick_n && !done_n) begin
            if (m_owed == MAXP) m_err = 1'b1;
            else m_owed++;
        end else if (done_n && !tick_n) begin
            m_owed--;
        end
        cyc++;
    endtask

    task automatic advance();
        @(posedge CK_t);
        #1;
        if (rand_in) begin
            bus.ctrl_idle = ($urandom_range(0, 99) < idle_pct);
            if ($urandom_range(0, 19) == 0) bus.banks_open = ~bus.banks_open;
        end
        if (auto_ack) bus.cmd_ack = bus.cmd_valid && ($urandom_range(0, 99) < ack_pct);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            sample();
            advance();
        end
    endtask

    task automatic ack_one();
        bus.cmd_ack = 1'b1;
        sample();
        advance();
        bus.cmd_ack = 1'b0;
    endtask

    initial begin
        int n_ref;
        int last_ref;
        int k;

        reset = 1'b1;
        init_done = 1'b0;
        bus.ctrl_idle = 1'b0;
        bus.banks_open = 1'b0;
        bus.cmd_ack = 1'b0;

        // directed tables start on the first tick cycle (elapsed 99)
        add(1,  1, 0, 0, 0, 0, CMD_NOP,  0);
        add(1,  1, 0, 0, 1, 0, CMD_NOP,  1);
        add(1,  1, 0, 1, 1, 1, CMD_REF,  1);
        add(19, 1, 0, 0, 1, 0, CMD_NOP,  1);
        add(5,  1, 0, 0, 0, 0, CMD_NOP,  0);
        add(73, 1, 1, 0, 0, 0, CMD_NOP,  0);
        add(1,  1, 1, 0, 0, 0, CMD_NOP,  0);
        add(1,  1, 1, 0, 1, 0, CMD_NOP,  1);
        add(2,  1, 1, 0, 1, 1, CMD_PREA, 1);
        add(1,  1, 1, 1, 1, 1, CMD_PREA, 1);
        add(4,  1, 1, 0, 1, 0, CMD_NOP,  1);
        add(1,  1, 1, 0, 1, 1, CMD_REF,  1);
        add(1,  1, 1, 1, 1, 1, CMD_REF,  1);
        add(19, 1, 1, 0, 1, 0, CMD_NOP,  1);
        add(3,  1, 1, 0, 0, 0, CMD_NOP,  0);

        run(3);
        check("rst_block", int'(bus.block_cmd), 0);
        check("rst_valid", int'(bus.cmd_valid), 0);
        check("rst_type", int'(bus.cmd_type), int'(CMD_NOP));
        check("rst_owed", int'(refresh_owed), 0);
        check("rst_urgent", int'(urgent), 0);
        check("rst_err", int'(refresh_err), 0);

        reset = 1'b0;
        init_done = 1'b1;
        bus.ctrl_idle = 1'b1;
        run(T_REFI - 1);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                bus.ctrl_idle = tbl[i].idle;
                bus.banks_open = tbl[i].bo;
                bus.cmd_ack = tbl[i].ack;
                sample();
                check("tbl_block", int'(bus.block_cmd), int'(tbl[i].blk));
                check("tbl_valid", int'(bus.cmd_valid), int'(tbl[i].vld));
                check("tbl_type", int'(bus.cmd_type), int'(tbl[i].typ));
                check("tbl_owed", int'(refresh_owed), tbl[i].owed);
                advance();
            end
        end
        bus.cmd_ack = 1'b0;

        // tick on the final tRFC cycle: owed holds and REF follows back-to-back
        bus.ctrl_idle = 1'b0;
        bus.banks_open = 1'b0;
        for (k = 0; k < 300 && refresh_owed != 4'd1; k++) run(1);
        check("coinc_owed_up", int'(refresh_owed), 1);
        bus.ctrl_idle = 1'b1;
        for (k = 0; k < 200 && m_elapsed != T_REFI - T_RFC; k++) run(1);
        check("coinc_ref_pending", int'(bus.cmd_valid && bus.cmd_type == CMD_REF), 1);
        ack_one();
        run(T_RFC - 1);
        check("coinc_owed_hold", int'(refresh_owed), 1);
        check("coinc_b2b_valid", int'(bus.cmd_valid), 1);
        check("coinc_b2b_type", int'(bus.cmd_type), int'(CMD_REF));
        check("coinc_block", int'(bus.block_cmd), 1);
        ack_one();
        run(T_RFC - 1);
        check("coinc_owed_done", int'(refresh_owed), 0);
        check("coinc_block_done", int'(bus.block_cmd), 0);

        // busy arbiter through nine ticks: saturation, error, forced drain
        bus.ctrl_idle = 1'b0;
        bus.banks_open = 1'b1;
        for (k = 0; k < 1200 && refresh_err != 1'b1; k++) run(1);
        check("sat_err", int'(refresh_err), 1);
        check("sat_owed", int'(refresh_owed), MAXP);
        check("sat_urgent", int'(urgent), 1);
        check("sat_forced_drain", int'(bus.block_cmd), 1);
        check("sat_wait_idle", int'(bus.cmd_valid), 0);
        bus.ctrl_idle = 1'b1;
        bus.cmd_ack = 1'b0;
        auto_ack = 1'b1;
        ack_pct = 100;
        n_ref = 0;
        last_ref = 0;
        for (k = 0; k < 600; k++) begin
            run(1);
            if (bus.cmd_valid && bus.cmd_ack && bus.cmd_type == CMD_REF) begin
                if (n_ref > 0) check("b2b_gap", cyc - last_ref, T_RFC);
                last_ref = cyc;
                n_ref++;
            end
            if (refresh_owed == 4'd0 && !bus.block_cmd) break;
        end
        check("burst_ref_count", int'(n_ref >= MAXP), 1);
        check("burst_owed_zero", int'(refresh_owed), 0);
        check("burst_block_low", int'(bus.block_cmd), 0);
        check("err_sticky", int'(refresh_err), 1);
        auto_ack = 1'b0;
        bus.cmd_ack = 1'b0;

        // reset during tRFC wait
        bus.ctrl_idle = 1'b0;
        bus.banks_open = 1'b0;
        for (k = 0; k < 300 && refresh_owed != 4'd1; k++) run(1);
        bus.ctrl_idle = 1'b1;
        for (k = 0; k < 10 && !bus.cmd_valid; k++) run(1);
        check("mid_rst_ref_valid", int'(bus.cmd_valid), 1);
        ack_one();
        run(5);
        reset = 1'b1;
        #1;
        check("async_rst_block", int'(bus.block_cmd), 0);
        check("async_rst_valid", int'(bus.cmd_valid), 0);
        check("async_rst_type", int'(bus.cmd_type), int'(CMD_NOP));
        check("async_rst_owed", int'(refresh_owed), 0);
        check("async_rst_urgent", int'(urgent), 0);
        check("async_rst_err", int'(refresh_err), 0);
        sample();
        advance();
        reset = 1'b0;
        for (int r = 0; r < 90; r++) begin
            sample();
            check("post_rst_no_cmd", int'(bus.cmd_valid), 0);
            check("post_rst_no_block", int'(bus.block_cmd), 0);
            advance();
        end

        // random traffic against the model
        rand_in = 1'b1;
        idle_pct = 60;
        auto_ack = 1'b1;
        ack_pct = 50;
        for (int r = 0; r < 4000; r++) begin
            if (r % 700 == 350) init_done = 1'b0;
            if (r % 700 == 380) init_done = 1'b1;
            run(1);
        end
        init_done = 1'b1;
        rand_in = 1'b0;
        bus.ctrl_idle = 1'b1;
        ack_pct = 100;
        for (k = 0; k < 1000; k++) begin
            run(1);
            if (refresh_owed == 4'd0 && !bus.block_cmd) break;
        end
        check("final_drain_owed", int'(refresh_owed), 0);
        check("final_drain_block", int'(bus.block_cmd), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
